approx_mul_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively characterises an exact/approximate multiplier pair by sweeping all 2^(2W) operand combinations.
- Drives shared operands into both multipliers, waits the datapath latency, then samples both products.
- Accumulates error statistics: error count, summed and maximum error distance, first failing vector.
- Sits between the ATPG/characterisation testbench or host and the multiplier datapath; replaces the purely combinational error comparator with a threshold-programmable, counted measurement.

---
 rtl/approx_mul_sweep_ctrl_if.sv | 16 +
 rtl/approx_mul_sweep_ctrl.sv | 156 +++++++++++++++
 tb/tb_approx_mul_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mul_sweep_ctrl_if.sv
// Operand/product bus between the sweep controller and the multiplier pair.
//   op_a, op_b : shared operands driven to both multipliers
//   exact_p    : product from the exact multiplier
//   approx_p   : product from the approximate multiplier
// master = controller side, slave = multiplier datapath side.
interface approx_mul_sweep_ctrl_if #(
  parameter int W = 2
);
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [2*W-1:0] exact_p;
  logic [2*W-1:0] approx_p;

  modport master (output op_a, output op_b, input exact_p, input approx_p);
  modport slave  (input op_a, input op_b, output exact_p, output approx_p);
endinterface

// File: rtl/approx_mul_sweep_ctrl.sv
// Exhaustive characterisation sequencer for an exact/approximate multiplier
// pair. Steps through every operand combination, waits LAT cycles for the
// datapath, then accumulates error distance (ED = |exact - approx|)
// statistics.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, abort    : begin a sweep (IDLE/DONE only), stop an active sweep
//   ed_thresh       : a vector is an error when ED > ed_thresh
//   mul             : operand/product bus (master side)
//   busy, done      : sweep active, one-cycle completion pulse
//   err_cnt, sum_ed, max_ed, fail_seen, first_fail_a/b : sweep statistics
//
// state | meaning
// IDLE  | waiting for start, statistics held
// APPLY | operands driven; counting down latency, sampling at wait_cnt == 0
// DONE  | sweep complete, done pulse for one cycle
module approx_mul_sweep_ctrl #(
  parameter int W   = 2,
  parameter int LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [2*W-1:0]          ed_thresh,
  approx_mul_sweep_ctrl_if.master mul,
  output logic                    busy,
  output logic                    done,
  output logic [2*W:0]            err_cnt,
  output logic [4*W-1:0]          sum_ed,
  output logic [2*W-1:0]          max_ed,
  output logic                    fail_seen,
  output logic [W-1:0]            first_fail_a,
  output logic [W-1:0]            first_fail_b
);

  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [2*W-1:0]  idx;
  logic [CW-1:0]   wait_cnt;
  logic            clear_stats;
  logic            dec_wait;
  logic            sample;
  logic            last_vec;
  logic [2*W-1:0]  ed;

  // Operands come straight from the index register, so they only move on
  // the edge that leaves a sample cycle.
  assign mul.op_a = idx[2*W-1:W];
  assign mul.op_b = idx[W-1:0];

  assign last_vec = (idx == '1);

  // Subtract in whichever direction stays non-negative so ED never wraps.
  assign ed = (mul.exact_p >= mul.approx_p) ? (mul.exact_p - mul.approx_p)
                                            : (mul.approx_p - mul.exact_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    clear_stats = 1'b0;
    dec_wait    = 1'b0;
    sample      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_stats = 1'b1;
          state_nxt   = APPLY;
        end
      end
      APPLY: begin
        busy = 1'b1;
        // abort wins over a coincident sample; that sample is dropped.
        if (abort) begin
          state_nxt = IDLE;
        end else if (wait_cnt != '0) begin
          dec_wait = 1'b1;
        end else begin
          sample = 1'b1;
          if (last_vec) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          clear_stats = 1'b1;
          state_nxt   = APPLY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      wait_cnt     <= '0;
      err_cnt      <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
      fail_seen    <= 1'b0;
      first_fail_a <= '0;
      first_fail_b <= '0;
    end else if (clear_stats) begin
      idx          <= '0;
      wait_cnt     <= CW'(LAT);
      err_cnt      <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
      fail_seen    <= 1'b0;
      first_fail_a <= '0;
      first_fail_b <= '0;
    end else if (dec_wait) begin
      wait_cnt <= wait_cnt - CW'(1);
    end else if (sample) begin
      sum_ed <= sum_ed + {{(2*W){1'b0}}, ed};
      if (ed > max_ed) begin
        max_ed <= ed;
      end
      if (ed > ed_thresh) begin
        err_cnt <= err_cnt + (2*W+1)'(1);
        if (!fail_seen) begin
          fail_seen    <= 1'b1;
          first_fail_a <= mul.op_a;
          first_fail_b <= mul.op_b;
        end
      end
      if (!last_vec) begin
        idx      <= idx + (2*W)'(1);
        wait_cnt <= CW'(LAT);
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_sweep_ctrl.sv
module tb_approx_mul_sweep_ctrl;

  typedef struct packed {
    logic [4:0] err;
    logic [7:0] sum;
    logic [3:0] mx;
    logic       fs;
    logic [1:0] fa;
    logic [1:0] fb;
  } stats_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1, abort;
  logic [3:0] ed_thresh;
  int         approx_mode;
  int         cur;
  int         n_vec = 0;
  int         n_bad = 0;
  stats_t     exp_q[$];

  logic       busy0, done0, fs0, busy1, done1, fs1;
  logic [4:0] err0, err1;
  logic [7:0] sum0, sum1;
  logic [3:0] max0, max1;
  logic [1:0] ffa0, ffb0, ffa1, ffb1;

  always #5 clk = ~clk;

  approx_mul_sweep_ctrl_if #(.W(2)) mif0 ();
  approx_mul_sweep_ctrl_if #(.W(2)) mif1 ();

  approx_mul_sweep_ctrl #(.W(2), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .ed_thresh(ed_thresh), .mul(mif0), .busy(busy0), .done(done0),
    .err_cnt(err0), .sum_ed(sum0), .max_ed(max0), .fail_seen(fs0),
    .first_fail_a(ffa0), .first_fail_b(ffb0)
  );

  approx_mul_sweep_ctrl #(.W(2), .LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .ed_thresh(ed_thresh), .mul(mif1), .busy(busy1), .done(done1),
    .err_cnt(err1), .sum_ed(sum1), .max_ed(max1), .fail_seen(fs1),
    .first_fail_a(ffa1), .first_fail_b(ffb1)
  );

  // Behavioural multiplier pair: mode 0 = OR-compressed 2x2 (3*3 -> 7),
  // mode 1 = approx always exact+1.
  function automatic logic [3:0] ex_f(input logic [1:0] a, input logic [1:0] b);
    return 4'(a) * 4'(b);
  endfunction

  function automatic logic [3:0] ap_f(input int mode, input logic [1:0] a, input logic [1:0] b);
    logic [3:0] e;
    e = ex_f(a, b);
    if (mode == 1) return e + 4'd1;
    return (a == 2'd3 && b == 2'd3) ? 4'd7 : e;
  endfunction

  assign mif0.exact_p  = ex_f(mif0.op_a, mif0.op_b);
  assign mif0.approx_p = ap_f(approx_mode, mif0.op_a, mif0.op_b);

  logic [3:0] e_s1, a_s1, e_s2, a_s2;
  always @(posedge clk) begin
    e_s1 <= ex_f(mif1.op_a, mif1.op_b);
    a_s1 <= ap_f(approx_mode, mif1.op_a, mif1.op_b);
    e_s2 <= e_s1;
    a_s2 <= a_s1;
  end
  assign mif1.exact_p  = e_s2;
  assign mif1.approx_p = a_s2;

  logic       o_busy, o_done;
  logic [3:0] o_op;
  stats_t     o_st;
  assign o_busy = (cur == 1) ? busy1 : busy0;
  assign o_done = (cur == 1) ? done1 : done0;
  assign o_op   = (cur == 1) ? {mif1.op_a, mif1.op_b} : {mif0.op_a, mif0.op_b};
  assign o_st   = (cur == 1) ? {err1, sum1, max1, fs1, ffa1, ffb1}
                             : {err0, sum0, max0, fs0, ffa0, ffb0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic stats_t model(input int mode, input logic [3:0] thr);
    stats_t     s;
    logic [3:0] e, p, d;
    s = '0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        e = ex_f(a[1:0], b[1:0]);
        p = ap_f(mode, a[1:0], b[1:0]);
        d = (e > p) ? e - p : p - e;
        s.sum = s.sum + 8'(d);
        if (d > s.mx) s.mx = d;
        if (d > thr) begin
          s.err = s.err + 5'd1;
          if (!s.fs) begin
            s.fs = 1'b1;
            s.fa = a[1:0];
            s.fb = b[1:0];
          end
        end
      end
    end
    return s;
  endfunction

  task automatic run_sweep(input int sel, input logic [3:0] thr, input int mode,
                           input int lat, input bit mid_start);
    int     busy_cnt, run_len;
    bit     done_seen;
    logic [3:0] prev_op;
    stats_t e;
    cur         = sel;
    ed_thresh   = thr;
    approx_mode = mode;
    exp_q.push_back(model(mode, thr));
    busy_cnt  = 0;
    run_len   = 0;
    done_seen = 1'b0;
    prev_op   = '0;
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      @(negedge clk);
      if (c == 0) begin start0 = 1'b0; start1 = 1'b0; end
      if (mid_start && busy_cnt == 5) start0 = 1'b1;
      if (mid_start && busy_cnt == 6) start0 = 1'b0;
      if (o_busy) begin
        busy_cnt++;
        if (run_len == 0 || o_op == prev_op) begin
          run_len++;
        end else begin
          check("op_stable_cycles", run_len, lat + 1);
          run_len = 1;
        end
        prev_op = o_op;
      end
      if (o_done) begin
        done_seen = 1'b1;
        check("done_busy_low", {31'd0, o_busy}, 0);
        check("last_op_stable_cycles", run_len, lat + 1);
        check("busy_cycles", busy_cnt, 16 * (lat + 1));
        e = exp_q.pop_front();
        check("err_cnt", o_st.err, e.err);
        check("sum_ed", o_st.sum, e.sum);
        check("max_ed", o_st.mx, e.mx);
        check("fail_seen", o_st.fs, e.fs);
        check("first_fail_a", o_st.fa, e.fa);
        check("first_fail_b", o_st.fb, e.fb);
      end
    end
    check("done_seen", {31'd0, done_seen}, 1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, o_done}, 0);
    check("idle_after_done", {31'd0, o_busy}, 0);
  endtask

  initial begin
    int cnt, dcnt;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    ed_thresh = '0; approx_mode = 0; cur = 0;
    #1;
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_done", {31'd0, done0}, 0);
    check("rst_op", {28'd0, mif0.op_a, mif0.op_b}, 0);
    check("rst_stats", {13'd0, err0, sum0, max0, fs0, ffa0, ffb0}, 0);
    check("rst_busy_lat2", {31'd0, busy1}, 0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    run_sweep(0, 4'd0, 0, 0, 1'b0);
    run_sweep(0, 4'd2, 0, 0, 1'b0);
    run_sweep(1, 4'd0, 0, 2, 1'b0);
    run_sweep(0, 4'd0, 1, 0, 1'b0);

    // abort in the 8th busy cycle
    cur = 0; approx_mode = 0; ed_thresh = 4'd0;
    cnt = 0;
    @(negedge clk) start0 = 1'b1;
    for (int c = 0; c < 50 && cnt < 8; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (busy0) cnt++;
    end
    check("abort_reach", cnt, 8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy0}, 0);
    dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (done0) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);
    check("abort_busy_held", {31'd0, busy0}, 0);
    check("abort_err_cnt", err0, 0);
    check("abort_sum_ed", sum0, 0);
    check("abort_fail_seen", {31'd0, fs0}, 0);

    run_sweep(0, 4'd0, 0, 0, 1'b1);

    // async reset in the middle of a +1 sweep
    cur = 0; approx_mode = 1; ed_thresh = 4'd0;
    cnt = 0;
    @(negedge clk) start0 = 1'b1;
    for (int c = 0; c < 50 && cnt < 10; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (busy0) cnt++;
    end
    check("prereset_sum_ed", sum0, 9);
    check("prereset_fail_seen", {31'd0, fs0}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy0}, 0);
    check("async_rst_op", {28'd0, mif0.op_a, mif0.op_b}, 0);
    check("async_rst_err_cnt", err0, 0);
    check("async_rst_sum_ed", sum0, 0);
    check("async_rst_max_ed", max0, 0);
    check("async_rst_fail", {29'd0, fs0, ffa0 | ffb0}, 0);
    @(negedge clk) rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy0 || done0) dcnt++;
    end
    check("post_reset_idle", dcnt, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
